// File: rtl/alu_mc.sv
// alu_mc: multi-cycle 6502 ALU with valid/ready handshake, rotate-through-carry,
// SUB/BIT/CMP, overflow flag and optional BCD decimal adjust (one extra state).
module alu_mc #(
  parameter int WIDTH      = 8,
  parameter int FLAG_W     = 7,
  parameter int DECIMAL_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        alu_op,
  input  logic [WIDTH-1:0]  inputA,
  input  logic [WIDTH-1:0]  inputB,
  input  logic [FLAG_W-1:0] status_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic [FLAG_W-1:0] flags_out
);

  // Opcodes (alu_ops.vh)
  localparam logic [4:0] OP_ASL = 5'd0;
  localparam logic [4:0] OP_LSR = 5'd1;
  localparam logic [4:0] OP_ROL = 5'd2;
  localparam logic [4:0] OP_ROR = 5'd3;
  localparam logic [4:0] OP_AND = 5'd4;
  localparam logic [4:0] OP_OR  = 5'd5;
  localparam logic [4:0] OP_XOR = 5'd6;
  localparam logic [4:0] OP_INC = 5'd7;
  localparam logic [4:0] OP_DEC = 5'd8;
  localparam logic [4:0] OP_ADD = 5'd9;
  localparam logic [4:0] OP_SUB = 5'd10;
  localparam logic [4:0] OP_CMP = 5'd11;
  localparam logic [4:0] OP_BIT = 5'd12;
  localparam logic [4:0] OP_FLG = 5'd13;

  // Status bit positions (status_register.vh)
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_D = 3;
  localparam int FLAG_V = 5;
  localparam int FLAG_N = 6;

  typedef enum logic [1:0] {IDLE, EXEC, DADJ, DONE} state_t;

  state_t            state, state_nxt;
  logic [4:0]        op_p0;
  logic [WIDTH-1:0]  a_p0, b_p0;
  logic [FLAG_W-1:0] st_p0;
  logic [WIDTH-1:0]  res_p1;
  logic [FLAG_W-1:0] flg_p1;
  logic [WIDTH:0]    dec_p2;
  logic              go_dec;

  // Nibble-serial BCD add; returns {carry_out, sum}.
  function automatic logic [WIDTH:0] bcd_add(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic cin);
    logic [WIDTH-1:0] r;
    logic             c;
    logic [4:0]       s;
    r = '0;
    c = cin;
    for (int i = 0; i < WIDTH / 4; i++) begin
      s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
      if (s > 5'd9) begin
        s = s + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[4*i +: 4] = s[3:0];
    end
    return {c, r};
  endfunction

  // Nibble-serial BCD subtract; carry in/out are "no borrow" as on the 6502.
  function automatic logic [WIDTH:0] bcd_sub(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic cin);
    logic [WIDTH-1:0] r;
    logic             bw;
    logic [4:0]       s;
    r  = '0;
    bw = ~cin;
    for (int i = 0; i < WIDTH / 4; i++) begin
      s  = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'b0, bw};
      bw = s[4];
      if (bw) s = s - 5'd6;
      r[4*i +: 4] = s[3:0];
    end
    return {~bw, r};
  endfunction

  // ---- stage p1: binary result and flags from the captured operands ----
  // Combinational binary ALU; untouched flags pass through from the captured status.
  always_comb begin
    logic [WIDTH-1:0] bop;
    logic [WIDTH:0]   sum;
    logic             cin;
    logic             upd_zn;
    res_p1 = '0;
    flg_p1 = st_p0;
    upd_zn = 1'b1;
    cin    = st_p0[FLAG_C];
    bop    = (op_p0 == OP_SUB) ? ~b_p0 : b_p0;
    sum    = {1'b0, a_p0} + {1'b0, bop} + {{WIDTH{1'b0}}, cin};
    case (op_p0)
      OP_ASL: begin res_p1 = {a_p0[WIDTH-2:0], 1'b0}; flg_p1[FLAG_C] = a_p0[WIDTH-1]; end
      OP_LSR: begin res_p1 = {1'b0, a_p0[WIDTH-1:1]}; flg_p1[FLAG_C] = a_p0[0]; end
      OP_ROL: begin res_p1 = {a_p0[WIDTH-2:0], cin};  flg_p1[FLAG_C] = a_p0[WIDTH-1]; end
      OP_ROR: begin res_p1 = {cin, a_p0[WIDTH-1:1]};  flg_p1[FLAG_C] = a_p0[0]; end
      OP_AND: res_p1 = a_p0 & b_p0;
      OP_OR:  res_p1 = a_p0 | b_p0;
      OP_XOR: res_p1 = a_p0 ^ b_p0;
      OP_INC: res_p1 = a_p0 + 1'b1;
      OP_DEC: res_p1 = a_p0 - 1'b1;
      OP_ADD, OP_SUB: begin
        res_p1         = sum[WIDTH-1:0];
        flg_p1[FLAG_C] = sum[WIDTH];
        flg_p1[FLAG_V] = (a_p0[WIDTH-1] == bop[WIDTH-1]) && (sum[WIDTH-1] != a_p0[WIDTH-1]);
      end
      OP_CMP: begin
        // Difference drives Z/N; the accumulator itself is returned.
        sum            = {1'b0, a_p0} + {1'b0, ~b_p0} + {{WIDTH{1'b0}}, 1'b1};
        res_p1         = a_p0;
        flg_p1[FLAG_C] = sum[WIDTH];
        flg_p1[FLAG_Z] = (sum[WIDTH-1:0] == '0);
        flg_p1[FLAG_N] = sum[WIDTH-1];
        upd_zn         = 1'b0;
      end
      OP_BIT: begin
        res_p1         = a_p0;
        flg_p1[FLAG_Z] = ((a_p0 & b_p0) == '0);
        flg_p1[FLAG_N] = b_p0[WIDTH-1];
        flg_p1[FLAG_V] = b_p0[WIDTH-2];
        upd_zn         = 1'b0;
      end
      OP_FLG: res_p1 = a_p0;
      default: upd_zn = 1'b0;
    endcase
    if (upd_zn) begin
      flg_p1[FLAG_Z] = (res_p1 == '0);
      flg_p1[FLAG_N] = res_p1[WIDTH-1];
    end
  end

  // ---- stage p2: BCD correction of result and carry ----
  // Decimal path is recomputed nibble by nibble from the captured operands.
  always_comb begin
    dec_p2 = (op_p0 == OP_SUB) ? bcd_sub(a_p0, b_p0, st_p0[FLAG_C])
                               : bcd_add(a_p0, b_p0, st_p0[FLAG_C]);
    go_dec = (DECIMAL_EN != 0) && st_p0[FLAG_D] && ((op_p0 == OP_ADD) || (op_p0 == OP_SUB));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = EXEC;
      end
      EXEC: state_nxt = go_dec ? DADJ : DONE;
      DADJ: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0: operand capture; result/flag registers written in EXEC and DADJ ----
  // Datapath registers; held stable in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_p0     <= '0;
      a_p0      <= '0;
      b_p0      <= '0;
      st_p0     <= '0;
      result    <= '0;
      flags_out <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_p0 <= alu_op;
          a_p0  <= inputA;
          b_p0  <= inputB;
          st_p0 <= status_in;
        end
        EXEC: begin
          result    <= res_p1;
          flags_out <= flg_p1;
        end
        DADJ: begin
          result            <= dec_p2[WIDTH-1:0];
          flags_out[FLAG_C] <= dec_p2[WIDTH];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed, table-driven bench for alu_mc (WIDTH=8, FLAG_W=7).
// Flag bits: C=0 Z=1 I=2 D=3 B=4 V=5 N=6.
module tb_alu_mc;
  localparam logic [4:0] ASL = 5'd0,  LSR = 5'd1,  ROL = 5'd2,  ROR = 5'd3;
  localparam logic [4:0] AND_ = 5'd4, OR_ = 5'd5,  XOR_ = 5'd6, INC = 5'd7;
  localparam logic [4:0] DEC = 5'd8,  ADD = 5'd9,  SUB = 5'd10, CMP = 5'd11;
  localparam logic [4:0] BIT_ = 5'd12, FLG = 5'd13, BAD = 5'd31;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iv1, iv0, ordy1, ordy0;
  logic [4:0] op;
  logic [7:0] a, b;
  logic [6:0] st;
  logic       ir1, ov1, ir0, ov0;
  logic [7:0] res1, res0;
  logic [6:0] fl1, fl0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(8), .FLAG_W(7), .DECIMAL_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .alu_op(op),
    .inputA(a), .inputB(b), .status_in(st), .out_valid(ov1), .out_ready(ordy1),
    .result(res1), .flags_out(fl1));

  alu_mc #(.WIDTH(8), .FLAG_W(7), .DECIMAL_EN(0)) dut_nodec (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .alu_op(op),
    .inputA(a), .inputB(b), .status_in(st), .out_valid(ov0), .out_ready(ordy0),
    .result(res0), .flags_out(fl0));

  typedef struct {
    logic [4:0] op;
    logic [7:0] a, b;
    logic [6:0] st;
    logic [7:0] res;
    logic [6:0] fl;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [4:0] o, input logic [7:0] xa, input logic [7:0] xb,
                              input logic [6:0] xs, input logic [7:0] r, input logic [6:0] f,
                              input int l);
    vec_t v;
    v.op = o; v.a = xa; v.b = xb; v.st = xs; v.res = r; v.fl = f; v.lat = l;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Present a request; the DUT is idle so it is accepted at the next posedge.
  task automatic issue(input bit sel, input logic [4:0] o, input logic [7:0] xa,
                       input logic [7:0] xb, input logic [6:0] xs);
    op = o; a = xa; b = xb; st = xs;
    if (sel) iv1 = 1'b1; else iv0 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0; iv0 = 1'b0;
  endtask

  // Edges after the accept edge until out_valid is seen (1 = binary, 2 = decimal).
  task automatic await(input bit sel, output int lat);
    lat = 99;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if ((sel ? ov1 : ov0) === 1'b1) begin lat = k; break; end
    end
  endtask

  task automatic release_out(input bit sel);
    if (sel) ordy1 = 1'b1; else ordy0 = 1'b1;
    @(posedge clk); #1;
    ordy1 = 1'b0; ordy0 = 1'b0;
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; iv1 = 0; iv0 = 0; ordy1 = 0; ordy0 = 0; op = '0; a = '0; b = '0; st = '0;

    //        op    A      B      status  result flags  latency
    vecs.push_back(mk(ADD,  8'h50, 8'h50, 7'h00, 8'hA0, 7'h60, 1));
    vecs.push_back(mk(ADD,  8'h58, 8'h46, 7'h09, 8'h05, 7'h69, 2));
    vecs.push_back(mk(SUB,  8'h46, 8'h12, 7'h09, 8'h34, 7'h09, 2));
    vecs.push_back(mk(CMP,  8'h10, 8'h20, 7'h00, 8'h10, 7'h40, 1));
    vecs.push_back(mk(CMP,  8'h20, 8'h20, 7'h00, 8'h20, 7'h03, 1));
    vecs.push_back(mk(ROR,  8'h01, 8'h00, 7'h05, 8'h80, 7'h45, 1));
    vecs.push_back(mk(BIT_, 8'h01, 8'hC0, 7'h00, 8'h01, 7'h62, 1));
    vecs.push_back(mk(ASL,  8'h81, 8'h00, 7'h00, 8'h02, 7'h01, 1));
    vecs.push_back(mk(LSR,  8'h01, 8'h00, 7'h40, 8'h00, 7'h03, 1));
    vecs.push_back(mk(ROL,  8'h80, 8'h00, 7'h00, 8'h00, 7'h03, 1));
    vecs.push_back(mk(AND_, 8'hF0, 8'h0F, 7'h21, 8'h00, 7'h23, 1));
    vecs.push_back(mk(OR_,  8'h80, 8'h01, 7'h00, 8'h81, 7'h40, 1));
    vecs.push_back(mk(XOR_, 8'hFF, 8'hFF, 7'h00, 8'h00, 7'h02, 1));
    vecs.push_back(mk(INC,  8'hFF, 8'h00, 7'h01, 8'h00, 7'h03, 1));
    vecs.push_back(mk(DEC,  8'h00, 8'h00, 7'h02, 8'hFF, 7'h40, 1));
    vecs.push_back(mk(FLG,  8'h80, 8'h00, 7'h03, 8'h80, 7'h41, 1));
    vecs.push_back(mk(BAD,  8'h12, 8'h34, 7'h5A, 8'h00, 7'h5A, 1));
    vecs.push_back(mk(SUB,  8'h50, 8'hB0, 7'h00, 8'h9F, 7'h60, 1));
    vecs.push_back(mk(ADD,  8'h99, 8'h01, 7'h08, 8'h00, 7'h49, 2));
    vecs.push_back(mk(SUB,  8'h10, 8'h01, 7'h09, 8'h09, 7'h09, 2));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", ov1, 0);
    chk("rst_in_ready", ir1, 1);
    chk("rst_result", res1, 0);
    chk("rst_flags", fl1, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      issue(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].st);
      await(1'b1, lat);
      chk($sformatf("v%0d_result", i), res1, vecs[i].res);
      chk($sformatf("v%0d_flags", i), fl1, vecs[i].fl);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      release_out(1'b1);
    end

    // Back-pressure: DONE holds while out_ready=0; in_valid and inputs are ignored.
    issue(1'b1, ADD, 8'h01, 8'h01, 7'h00);
    await(1'b1, lat);
    chk("stall_latency", lat, 1);
    for (int k = 0; k < 5; k++) begin
      iv1 = ~iv1; a = 8'hFF - 8'(k); b = 8'(k); op = SUB;
      @(posedge clk); #1;
      chk($sformatf("stall%0d_result", k), res1, 8'h02);
      chk($sformatf("stall%0d_flags", k), fl1, 7'h00);
      chk($sformatf("stall%0d_out_valid", k), ov1, 1);
      chk($sformatf("stall%0d_in_ready", k), ir1, 0);
    end
    iv1 = 1'b0;
    release_out(1'b1);
    chk("post_stall_in_ready", ir1, 1);
    @(posedge clk); #1;
    chk("post_stall_no_spurious", ov1, 0);

    // Reset while in DADJ discards the transaction.
    issue(1'b1, ADD, 8'h58, 8'h46, 7'h09);
    @(posedge clk); #1;
    chk("dadj_out_valid", ov1, 0);
    chk("dadj_binary_result", res1, 8'h9F);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("dadj_rst_out_valid", ov1, 0);
    chk("dadj_rst_result", res1, 0);
    chk("dadj_rst_flags", fl1, 0);
    chk("dadj_rst_in_ready", ir1, 1);
    rst_n = 1'b1;
    issue(1'b1, ADD, 8'h01, 8'h02, 7'h00);
    await(1'b1, lat);
    chk("after_rst_result", res1, 8'h03);
    chk("after_rst_latency", lat, 1);
    release_out(1'b1);

    // DECIMAL_EN=0: decimal flag ignored, binary result in the short latency.
    issue(1'b0, SUB, 8'h46, 8'h12, 7'h09);
    await(1'b0, lat);
    chk("nodec_result", res0, 8'h34);
    chk("nodec_flags", fl0, 7'h09);
    chk("nodec_latency", lat, 1);
    release_out(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
